// File: rtl/funct_generator_wave.sv
// Phase-accumulator waveform source (square/saw/triangle/zero) with a valid/ready
// output; rate and shape changes are only adopted when the phase wraps.
//
// state | meaning
// IDLE  | generator off, valid_o low
// RUN   | producing samples, advancing phase on each transfer
// DRAIN | disabled while a sample is still pending; hold it until taken
module funct_generator_wave #(
    parameter int DATA_WIDTH  = 8,
    parameter int PHASE_WIDTH = 16
) (
    input  logic                   clk_i,
    input  logic                   rst_i,
    input  logic                   enh,
    input  logic [1:0]             wave_sel_i,
    input  logic [PHASE_WIDTH-1:0] freq_i,
    input  logic                   ready_i,
    output logic                   valid_o,
    output logic [DATA_WIDTH-1:0]  data_o,
    output logic                   period_o
);

    typedef enum logic [1:0] {IDLE, RUN, DRAIN} state_t;

    state_t                 state, state_n;
    logic [PHASE_WIDTH-1:0] phase, phase_n;
    logic [PHASE_WIDTH-1:0] active_inc, inc_n;
    logic [1:0]             active_sel, sel_n;
    logic                   valid_n, period_n;
    logic [DATA_WIDTH-1:0]  data_n;
    logic [PHASE_WIDTH:0]   sum;
    logic                   xfer;

    function automatic logic [DATA_WIDTH-1:0] wave_fn(input logic [PHASE_WIDTH-1:0] ph,
                                                      input logic [1:0] sel);
        logic [DATA_WIDTH-1:0] t;
        logic [DATA_WIDTH-2:0] u;
        logic [DATA_WIDTH-1:0] r;
        t = ph[PHASE_WIDTH-1 -: DATA_WIDTH];
        u = t[DATA_WIDTH-1] ? ~t[DATA_WIDTH-2:0] : t[DATA_WIDTH-2:0];
        // Subtracting 2^(DATA_WIDTH-1) modulo 2^DATA_WIDTH is an MSB flip.
        case (sel)
            2'b00:   r = t[DATA_WIDTH-1] ? {1'b1, {(DATA_WIDTH-1){1'b0}}}
                                         : {1'b0, {(DATA_WIDTH-1){1'b1}}};
            2'b01:   r = {~t[DATA_WIDTH-1], t[DATA_WIDTH-2:0]};
            2'b10:   r = {~u[DATA_WIDTH-2], u[DATA_WIDTH-3:0], 1'b0};
            default: r = '0;
        endcase
        return r;
    endfunction

    assign xfer = valid_o & ready_i;
    assign sum  = {1'b0, phase} + {1'b0, active_inc};

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state      <= IDLE;
            phase      <= '0;
            active_inc <= '0;
            active_sel <= 2'b00;
            valid_o    <= 1'b0;
            data_o     <= '0;
            period_o   <= 1'b0;
        end else begin
            state      <= state_n;
            phase      <= phase_n;
            active_inc <= inc_n;
            active_sel <= sel_n;
            valid_o    <= valid_n;
            data_o     <= data_n;
            period_o   <= period_n;
        end
    end

    always_comb begin
        state_n  = state;
        phase_n  = phase;
        inc_n    = active_inc;
        sel_n    = active_sel;
        valid_n  = valid_o;
        data_n   = data_o;
        period_n = period_o;
        case (state)
            IDLE: begin
                valid_n = 1'b0;
                if (enh) begin
                    inc_n    = freq_i;
                    sel_n    = wave_sel_i;
                    phase_n  = '0;
                    data_n   = wave_fn({PHASE_WIDTH{1'b0}}, wave_sel_i);
                    period_n = 1'b1;
                    valid_n  = 1'b1;
                    state_n  = RUN;
                end
            end
            RUN: begin
                if (xfer) begin
                    phase_n = sum[PHASE_WIDTH-1:0];
                    if (sum[PHASE_WIDTH]) begin
                        inc_n    = freq_i;
                        sel_n    = wave_sel_i;
                        data_n   = wave_fn(sum[PHASE_WIDTH-1:0], wave_sel_i);
                        period_n = 1'b1;
                    end else begin
                        data_n   = wave_fn(sum[PHASE_WIDTH-1:0], active_sel);
                        period_n = 1'b0;
                    end
                end
                if (!enh) begin
                    if (!valid_o || xfer) begin
                        valid_n = 1'b0;
                        state_n = IDLE;
                    end else begin
                        state_n = DRAIN;
                    end
                end
            end
            DRAIN: begin
                if (xfer) begin
                    valid_n = 1'b0;
                    state_n = IDLE;
                end
            end
            default: begin
                valid_n = 1'b0;
                state_n = IDLE;
            end
        endcase
    end

endmodule

// File: tb/tb_funct_generator_wave.sv
// Directed vector bench for funct_generator_wave: each row drives inputs for one
// clock edge and gives the outputs expected just after that edge.
module tb_funct_generator_wave;

   logic        clk = 1'b0;
   logic        rst_i = 1'b1;
   logic        enh = 1'b0;
   logic [1:0]  wave_sel_i = 2'b00;
   logic [15:0] freq_i = '0;
   logic        ready_i = 1'b0;
   logic        valid_o;
   logic [7:0]  data_o;
   logic        period_o;

   int tests = 0;
   int fails = 0;

   funct_generator_wave #(.DATA_WIDTH(8), .PHASE_WIDTH(16)) dut (
      .clk_i(clk), .rst_i(rst_i), .enh(enh), .wave_sel_i(wave_sel_i),
      .freq_i(freq_i), .ready_i(ready_i), .valid_o(valid_o),
      .data_o(data_o), .period_o(period_o)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic        rst;
      logic        en;
      logic [1:0]  sel;
      logic [15:0] freq;
      logic        rdy;
      logic        ev;
      int          ed;
      logic        ep;
      logic        cd;   // when 0 only valid_o is checked
   } vec_t;

   vec_t vecs[$];

   function automatic void add(input logic r, input logic e, input logic [1:0] s,
                               input logic [15:0] f, input logic rd, input logic ev,
                               input int ed, input logic ep, input logic cd);
      vec_t v;
      v.rst = r; v.en = e; v.sel = s; v.freq = f; v.rdy = rd;
      v.ev = ev; v.ed = ed; v.ep = ep; v.cd = cd;
      vecs.push_back(v);
   endfunction

   initial begin
      #100000;
      fails++;
      $display("FAIL timeout: vector run did not complete");
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

   initial begin
      // reset, then sawtooth 0x1000: -128..112 then wrap
      add(1, 0, 0, 16'h0000, 0, 0, 0, 0, 1);
      add(0, 1, 1, 16'h1000, 1, 1, -128, 1, 1);
      for (int k = 1; k < 16; k++) add(0, 1, 1, 16'h1000, 1, 1, -128 + 16 * k, 0, 1);
      add(0, 1, 1, 16'h1000, 1, 1, -128, 1, 1);
      // mid-period request for square 0x2000: ignored until the wrap
      for (int k = 1; k < 5; k++) add(0, 1, 1, 16'h1000, 1, 1, -128 + 16 * k, 0, 1);
      for (int k = 5; k < 16; k++) add(0, 1, 0, 16'h2000, 1, 1, -128 + 16 * k, 0, 1);
      add(0, 1, 0, 16'h2000, 1, 1, 127, 1, 1);
      // backpressure on the period-start sample
      for (int k = 0; k < 3; k++) add(0, 1, 0, 16'h2000, 0, 1, 127, 1, 1);
      for (int k = 0; k < 3; k++) add(0, 1, 0, 16'h2000, 1, 1, 127, 0, 1);
      for (int k = 0; k < 4; k++) add(0, 1, 0, 16'h4000, 1, 1, -128, 0, 1);
      // square 0x4000
      add(0, 1, 0, 16'h4000, 1, 1, 127, 1, 1);
      add(0, 1, 0, 16'h4000, 1, 1, 127, 0, 1);
      add(0, 1, 0, 16'h4000, 1, 1, -128, 0, 1);
      add(0, 1, 0, 16'h4000, 1, 1, -128, 0, 1);
      add(0, 1, 0, 16'h4000, 1, 1, 127, 1, 1);
      add(0, 1, 0, 16'h4000, 1, 1, 127, 0, 1);
      add(0, 1, 2, 16'h4000, 1, 1, -128, 0, 1);
      add(0, 1, 2, 16'h4000, 1, 1, -128, 0, 1);
      // triangle 0x4000
      add(0, 1, 2, 16'h4000, 1, 1, -128, 1, 1);
      add(0, 1, 2, 16'h4000, 1, 1, 0, 0, 1);
      add(0, 1, 2, 16'h4000, 1, 1, 126, 0, 1);
      add(0, 1, 2, 16'h4000, 1, 1, -2, 0, 1);
      add(0, 1, 2, 16'h4000, 1, 1, -128, 1, 1);
      // disable while stalled: DRAIN holds, enh ignored, then idle
      add(0, 0, 2, 16'h4000, 0, 1, -128, 1, 1);
      add(0, 1, 2, 16'h4000, 0, 1, -128, 1, 1);
      add(0, 1, 2, 16'h4000, 1, 0, 0, 0, 0);
      // restart from phase 0, then disable on a transfer
      add(0, 1, 1, 16'h1000, 1, 1, -128, 1, 1);
      add(0, 1, 1, 16'h1000, 1, 1, -112, 0, 1);
      add(0, 0, 1, 16'h1000, 1, 0, 0, 0, 0);
      add(0, 0, 1, 16'h1000, 1, 0, 0, 0, 0);
      // reset mid-run, then restart
      add(0, 1, 2, 16'h4000, 1, 1, -128, 1, 1);
      add(0, 1, 2, 16'h4000, 1, 1, 0, 0, 1);
      add(1, 1, 2, 16'h4000, 1, 0, 0, 0, 1);
      add(0, 1, 2, 16'h4000, 1, 1, -128, 1, 1);
      add(0, 1, 2, 16'h4000, 1, 1, 0, 0, 1);
      add(0, 1, 2, 16'h4000, 1, 1, 126, 0, 1);
      // zero waveform
      add(1, 0, 0, 16'h0000, 0, 0, 0, 0, 1);
      add(0, 1, 3, 16'h4000, 1, 1, 0, 1, 1);
      add(0, 1, 3, 16'h4000, 1, 1, 0, 0, 1);
      // zero increment: sample repeats, no further period pulses
      add(1, 0, 0, 16'h0000, 0, 0, 0, 0, 1);
      add(0, 1, 1, 16'h0000, 1, 1, -128, 1, 1);
      add(0, 1, 1, 16'h0000, 1, 1, -128, 0, 1);
      add(0, 1, 1, 16'h0000, 1, 1, -128, 0, 1);

      rst_i = 1'b1;
      @(posedge clk);
      #1;
      tests++;
      if (valid_o !== 1'b0 || data_o !== 8'h00 || period_o !== 1'b0) begin
         fails++;
         $display("FAIL reset state: valid=%0b data=%0d period=%0b, expected all 0",
                  valid_o, $signed(data_o), period_o);
      end

      for (int i = 0; i < vecs.size(); i++) begin
         rst_i      = vecs[i].rst;
         enh        = vecs[i].en;
         wave_sel_i = vecs[i].sel;
         freq_i     = vecs[i].freq;
         ready_i    = vecs[i].rdy;
         @(posedge clk);
         #1;
         tests++;
         if (valid_o !== vecs[i].ev ||
             (vecs[i].cd && (data_o !== vecs[i].ed[7:0] || period_o !== vecs[i].ep))) begin
            fails++;
            $display("FAIL row%0d: valid=%0b data=%0d period=%0b, expected valid=%0b data=%0d period=%0b (data checked=%0b)",
                     i, valid_o, $signed(data_o), period_o,
                     vecs[i].ev, vecs[i].ed, vecs[i].ep, vecs[i].cd);
         end
      end

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule

// File: doc/funct_generator_wave.md
Name: funct_generator_wave

Overview:
- Phase-accumulator waveform source that feeds the function generator's 2-input multiplier. It produces the signed sample operand; the amplitude operand comes from elsewhere.
- Generates square, sawtooth, triangle or zero samples at a programmable phase increment.
- Uses a valid/ready handshake toward the consumer.
- Frequency and waveform changes take effect only at a period boundary, so no glitch is produced mid-period.

Parameters:
- DATA_WIDTH, 8, sample width (signed two's complement); must match multiplier operand width.
- PHASE_WIDTH, 16, phase accumulator width; must be ≥ DATA_WIDTH.

Ports:
- clk_i  input  1  clock.
- rst_i  input  1  synchronous, active-high reset.
- enh  input  1  generator enable.
- wave_sel_i  input  2  waveform request: 00 square, 01 sawtooth, 10 triangle, 11 zero.
- freq_i  input  PHASE_WIDTH  requested phase increment per accepted sample (unsigned).
- ready_i  input  1  consumer accepts the sample this cycle.
- valid_o  output  1  data_o holds a valid sample.
- data_o  output  DATA_WIDTH  signed sample.
- period_o  output  1  one-cycle pulse, registered with a sample that starts a new period.

Behaviour:
- Reset: rst_i=1 at a clock edge clears everything:
  - state=IDLE, phase=0, active_inc=0, active_sel=00.
  - valid_o=0, data_o=0, period_o=0.
  - Reset mid-operation discards any pending sample.
- Only one clock, clk_i. Reset is synchronous and active-high. Every register updates only on the rising edge.
- Transfer: a transfer occurs in a cycle where valid_o=1 and ready_i=1.
  - While valid_o=1 and ready_i=0, data_o, period_o and phase hold stable.
- Waveform function W(phase, sel): let t = phase[PHASE_WIDTH-1 -: DATA_WIDTH] (unsigned), H = 2^(DATA_WIDTH-1).
  - square: t MSB=0 → H-1, else → -H.
  - sawtooth: t - H, which is t with its MSB inverted.
  - triangle: u = t[DATA_WIDTH-2:0] if t MSB=0, else ~t[DATA_WIDTH-2:0]; result = {u,1'b0} - H.
  - zero: 0.
  - All results fit in DATA_WIDTH signed bits with no saturation logic needed.
- State IDLE:
  - valid_o=0.
  - If enh=1: active_inc ← freq_i, active_sel ← wave_sel_i, phase ← 0, data_o ← W(0, wave_sel_i), period_o ← 1, valid_o ← 1, go to RUN.
- State RUN, on a transfer:
  - next = phase + active_inc, computed with a PHASE_WIDTH+1 bit sum; carry = bit PHASE_WIDTH.
  - phase ← next[PHASE_WIDTH-1:0]; the wrap is modulo 2^PHASE_WIDTH.
  - If carry=1: active_inc ← freq_i, active_sel ← wave_sel_i, data_o ← W(next, wave_sel_i), period_o ← 1.
  - If carry=0: data_o ← W(next, active_sel), period_o ← 0.
- enh deassertion:
  - In RUN with enh=0 and no pending sample (valid_o=0, or a transfer this cycle): valid_o ← 0, go to IDLE.
  - In RUN with enh=0 and valid_o=1, ready_i=0: go to DRAIN.
  - DRAIN holds the sample until a transfer, then valid_o ← 0 and goes to IDLE.
  - enh has no effect in DRAIN.
- freq_i and wave_sel_i are sampled only at enable (IDLE→RUN) and on carry transfers. Changes at other times are ignored.
- active_inc=0: phase never advances, the same sample repeats, and period_o stays 0 after the first sample.
- Latency:
  - First valid sample appears 1 cycle after enh is sampled high.
  - Each next sample is available the cycle after a transfer, so sustained throughput is 1 sample/cycle with ready_i held high.

Test Plan:
- Reset, then sawtooth (sel=01, freq=0x1000, ready_i=1):
  - data_o sequence -128, -112, …, 112, then -128.
  - period_o=1 on the first sample and on the 17th.
- Square, freq=0x4000: data_o sequence 127, 127, -128, -128, repeating; period_o asserted every 4th sample.
- Triangle, freq=0x4000: data_o sequence -128, 0, 126, -2, then -128 on wrap.
- Backpressure: drop ready_i for 3 cycles mid-stream → valid_o stays 1, data_o and period_o are unchanged, and the sequence resumes with no skipped or duplicated sample.
- Mid-period change: switch freq_i to 0x2000 and sel to 00 at the 5th sawtooth sample → sawtooth continues to 112; the sample after wrap is square 127 and the period is now 8 samples.
- Control and reset corners:
  - enh=0 while ready_i=0 → enters DRAIN, holds the sample until ready_i=1, then valid_o=0.
  - Assert rst_i mid-run → next cycle valid_o=0, data_o=0, period_o=0.
  - Restarting with enh=1 begins again at phase 0.
